// File: rtl/alu_arbiter_if.sv
// Bundles the two request channels, the ALU operand/result wires and the
// response channel shared between alu_arbiter and its neighbours.
interface alu_arbiter_if #(
    parameter int WIDTH = 6,
    parameter int FXN_W = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [FXN_W-1:0] req0_fxn;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [FXN_W-1:0] req1_fxn;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [FXN_W-1:0] alu_fxn;
    logic [WIDTH-1:0] alu_x;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_x;
    logic             rsp_id;
    logic             busy;

    // Requesters, response consumer and the ALU instance.
    modport master (
        output req0_valid, req0_a, req0_b, req0_fxn,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_fxn,
        input  req1_ready,
        input  alu_a, alu_b, alu_fxn,
        output alu_x,
        input  rsp_valid, rsp_x, rsp_id, busy,
        output rsp_ready
    );

    // The arbiter itself.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fxn,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_fxn,
        output req1_ready,
        output alu_a, alu_b, alu_fxn,
        input  alu_x,
        output rsp_valid, rsp_x, rsp_id, busy,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters:
// latch operands, hold them on the ALU for SETTLE cycles, return X with an ID.
module alu_arbiter #(
    parameter int WIDTH  = 6,
    parameter int FXN_W  = 3,
    parameter int SETTLE = 1    // legal range 1..15
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [FXN_W-1:0] r_op_fxn;
    logic [3:0]       r_cnt;
    logic             r_last_grant;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_x;
    logic             r_rsp_id;
    logic             r_busy;

    logic             w_any_valid;
    logic             w_grant;
    logic             w_idle;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [FXN_W-1:0] w_sel_fxn;

    // With both valid the requester that lost last time wins; otherwise the lone one.
    always_comb begin
        w_any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = bus.req1_valid;
        end
        w_sel_a   = w_grant ? bus.req1_a   : bus.req0_a;
        w_sel_b   = w_grant ? bus.req1_b   : bus.req0_b;
        w_sel_fxn = w_grant ? bus.req1_fxn : bus.req0_fxn;
    end

    assign w_idle         = (r_state == IDLE);
    assign bus.req0_ready = w_idle && bus.req0_valid && !w_grant;
    assign bus.req1_ready = w_idle && bus.req1_valid &&  w_grant;

    assign bus.alu_a     = r_op_a;
    assign bus.alu_b     = r_op_b;
    assign bus.alu_fxn   = r_op_fxn;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_x     = r_rsp_x;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.busy      = r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_fxn     <= '0;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_x      <= '0;
            r_rsp_id     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_op_a       <= w_sel_a;
                        r_op_b       <= w_sel_b;
                        r_op_fxn     <= w_sel_fxn;
                        r_last_grant <= w_grant;
                        r_cnt        <= SETTLE_M1;
                        r_busy       <= 1'b1;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rsp_x     <= bus.alu_x;
                        r_rsp_id    <= r_last_grant;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 6-bit ALU (operands A, B; function select fxn; result X) between two requesters.
- Round-robin arbitration with valid/ready handshakes.
- The block drives the ALU operand/function inputs from registered operands, waits a programmable settle time, captures the result and returns it with a requester ID on a response channel with backpressure.
- Sits between requesters (sequencers/test drivers) and the ALU instance.

Parameters:
WIDTH, 6, operand/result width (matches ALU A, B, X)
FXN_W, 3, function-select width (matches ALU fxn)
SETTLE, 1, cycles operands are held on the ALU before X is sampled; legal range 1..15

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH  requester 0 operand A
req0_b  in  WIDTH  requester 0 operand B
req0_fxn  in  FXN_W  requester 0 function select
req1_valid, req1_ready, req1_a, req1_b, req1_fxn  same as requester 0, for requester 1
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_fxn  out  FXN_W  to ALU fxn
alu_x  in  WIDTH  from ALU X (combinational)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_x  out  WIDTH  captured ALU result
rsp_id  out  1  requester that issued the result
busy  out  1  high in EXEC or RESP

Behaviour:
- One clock (clk), synchronous active-low reset (rst_n); all state updates on the rising edge of clk.
- Reset (rst_n low at an edge):
  - state=IDLE; op_a, op_b, op_fxn=0 (so alu_a, alu_b, alu_fxn=0).
  - rsp_valid=0, rsp_x=0, rsp_id=0, busy=0.
  - settle counter=0; last_grant=1 (req0 wins the first contention).
- States: IDLE, EXEC, RESP. reqN_ready is high only in IDLE.
- Grant (IDLE, combinational):
  - Only one reqN_valid: grant=N.
  - Both valid: grant=~last_grant.
  - Neither valid: no grant.
- Ready: reqN_ready = (state==IDLE) && reqN_valid && grant==N. At most one ready is high per cycle. Ready never asserts without valid.
- Accept edge (IDLE, ready high):
  - Latch reqN_a/b/fxn into op regs; last_grant<=grant; cnt<=SETTLE-1; state->EXEC.
- EXEC:
  - alu_a/b/fxn = op regs, held stable throughout.
  - cnt!=0: cnt decrements.
  - cnt==0: rsp_x<=alu_x, rsp_id<=last_grant, rsp_valid<=1, state->RESP.
- RESP:
  - rsp_valid, rsp_x, rsp_id held stable until rsp_valid && rsp_ready.
  - On that edge: rsp_valid<=0, state->IDLE.
- No new accept in RESP or EXEC.
- Latency: accept at edge E gives rsp_valid high after edge E+SETTLE. Best-case throughput is one op per SETTLE+2 cycles (rsp_ready tied high).
- ALU outputs outside EXEC hold the last operation's operands; they are not forced to 0 except by reset.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1...
- A lone requester may win back-to-back operations; last_grant still updates.
- Requester deasserting valid before ready: no acceptance, no side effects.
- Requester changing operands while not ready: only the values at the accept edge matter.
- Reset mid-operation (EXEC or RESP): the operation is abandoned, no response is emitted, and all state returns to reset values at that edge.
- Reset has priority over every other event in the same cycle.
- rsp_ready high while rsp_valid low: ignored.
- Widths: no arithmetic in the block beyond the 4-bit settle down-counter. Result width equals WIDTH; no truncation or extension of alu_x.

Test Plan:
1. Single request, SETTLE=1, rsp_ready=1: req0 A=6'b011001, B=6'b101010, fxn=3'b000.
   - req0_ready high for 1 cycle; alu_a/b/fxn equal those values during EXEC.
   - rsp_valid exactly 1 edge after accept; rsp_x = ALU model output for those inputs; rsp_id=0.
2. Contention, both valid continuously: req0 (A=6'd60, B=6'd53, fxn=3'b101), req1 (A=6'b010010, B=6'b000011, fxn=3'b110), 4 operations.
   - rsp_id sequence 0,1,0,1; each rsp_x matches the ALU model for its requester's inputs.
3. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
   - rsp_valid, rsp_x, rsp_id stable; both req*_ready stay 0.
   - Releasing rsp_ready gives rsp_valid low next edge and IDLE.
4. SETTLE=4: req1 A=6'b111100, B=6'd15, fxn=3'b001.
   - alu_* stable for 4 cycles; rsp_valid 4 edges after accept; busy high from accept through the response handshake.
5. Reset mid-op: rst_n low for 1 cycle during EXEC.
   - Next edge: rsp_valid=0, busy=0, alu_*=0, no response emitted.
   - With both then valid, req0 granted first.
6. Lone requester: only req1 valid, A=6'd21, B=6'b001010, fxn=3'b110, twice.
   - Both granted to req1 back-to-back.
   - Then both valid: req0 wins.
